// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the MEM-stage access unit.
//   - access size codes (byte / half / word)
//   - FSM state encoding
//   - byte-lane count of the data bus
//   - is_aligned(): natural-alignment test for a size/offset pair
package mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam int unsigned NUM_LANES = 4;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } mem_state_e;

  // Size must already be normalised (2'b11 folded into SIZE_WORD).
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] offset);
    logic ok;
    case (size)
      SIZE_BYTE: ok = 1'b1;
      SIZE_HALF: ok = ~offset[0];
      default:   ok = (offset == 2'b00);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// mem_load_align: combinational load-data lane selection and extension.
// Ports:
//   rdata_i   [SIZE_DATA] raw word returned by data memory
//   offset_i  [2]         byte offset of the access within the word
//   size_i    [2]         normalised access size (SIZE_BYTE/HALF/WORD)
//   signed_i  [1]         1 = sign-extend, 0 = zero-extend
//   data_o    [SIZE_DATA] right-justified, extended load value
module mem_load_align
  import mem_pkg::*;
#(
  parameter int SIZE_DATA = 32
) (
  input  logic [SIZE_DATA-1:0] rdata_i,
  input  logic [1:0]           offset_i,
  input  logic [1:0]           size_i,
  input  logic                 signed_i,
  output logic [SIZE_DATA-1:0] data_o
);

  logic [SIZE_DATA-1:0] shifted;

  always_comb begin
    // Move the addressed lane down to bit 0 before extending.
    shifted = rdata_i >> {offset_i, 3'b000};
    case (size_i)
      SIZE_BYTE: data_o = {{(SIZE_DATA-8){signed_i & shifted[7]}}, shifted[7:0]};
      SIZE_HALF: data_o = {{(SIZE_DATA-16){signed_i & shifted[15]}}, shifted[15:0]};
      default:   data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store unit between the EX/MEM latch and
// MEM/WB. Memory ops become a req/ack access with byte enables and lane
// replication; ALU ops pass straight through with one cycle of latency.
//
// Optional build macro: MEM_TIMEOUT_EN enables an ACCESS watchdog of
// TIMEOUT_CYCLES cycles; without it o_timeout is tied 0.
//
// Handshake: o_mem_req is held high for every ACCESS cycle with o_mem_addr,
// o_mem_be, o_mem_we and o_mem_wdata stable; the access completes in the
// cycle i_mem_ack is high (i_mem_rdata valid in that same cycle). i_mem_ack
// outside ACCESS is ignored.
//
// Ports:
//   i_clk, i_reset_n          clock, async active-low reset
//   i_valid, i_mem_read, i_mem_write, i_size, i_signed, i_rd,
//   i_alu_result, i_rd_value  EX/MEM latch contents
//   o_stall                   freeze EX/MEM and earlier stages
//   o_mem_req, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata,
//   i_mem_ack, i_mem_rdata    data memory interface
//   o_valid, o_rd, o_result   toward MEM/WB
//   o_misaligned, o_timeout   one-cycle error pulses
//
// The FSM state is held in state_q (mem_state_e) for observation.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int SIZE_DATA      = 32,
  parameter int SIZE_REG       = 5,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_valid,
  input  logic                 i_mem_read,
  input  logic                 i_mem_write,
  input  logic [1:0]           i_size,
  input  logic                 i_signed,
  input  logic [SIZE_REG-1:0]  i_rd,
  input  logic [SIZE_DATA-1:0] i_alu_result,
  input  logic [SIZE_DATA-1:0] i_rd_value,
  output logic                 o_stall,
  output logic                 o_mem_req,
  output logic                 o_mem_we,
  output logic [SIZE_DATA-1:0] o_mem_addr,
  output logic [NUM_LANES-1:0] o_mem_be,
  output logic [SIZE_DATA-1:0] o_mem_wdata,
  input  logic                 i_mem_ack,
  input  logic [SIZE_DATA-1:0] i_mem_rdata,
  output logic                 o_valid,
  output logic [SIZE_REG-1:0]  o_rd,
  output logic [SIZE_DATA-1:0] o_result,
  output logic                 o_misaligned,
  output logic                 o_timeout
);

  mem_state_e state_q, state_d;

  // Captured access
  logic [SIZE_DATA-1:0] addr_q, addr_d;
  logic [NUM_LANES-1:0] be_q, be_d;
  logic                 we_q, we_d;
  logic [SIZE_DATA-1:0] wdata_q, wdata_d;
  logic [SIZE_REG-1:0]  rd_q, rd_d;
  logic [1:0]           size_q, size_d;
  logic                 signed_q, signed_d;
  logic [1:0]           off_q, off_d;

  // Result registers toward MEM/WB
  logic                 valid_q, valid_d;
  logic [SIZE_REG-1:0]  rd_out_q, rd_out_d;
  logic [SIZE_DATA-1:0] result_q, result_d;
  logic                 misaligned_q, misaligned_d;

  // Request decode
  logic                 is_read, is_write, mem_op, aligned;
  logic [1:0]           size_n, off_n;
  logic [NUM_LANES-1:0] be_n;
  logic [SIZE_DATA-1:0] wdata_n;
  logic [SIZE_DATA-1:0] load_data;
  logic                 abort;
  logic                 stall;

  // Read wins when both strobes are set; 2'b11 is handled as a word.
  assign is_read  = i_mem_read;
  assign is_write = i_mem_write & ~i_mem_read;
  assign mem_op   = is_read | is_write;
  assign size_n   = (i_size == SIZE_BYTE || i_size == SIZE_HALF) ? i_size : SIZE_WORD;
  assign off_n    = i_alu_result[1:0];
  assign aligned  = is_aligned(size_n, off_n);

  always_comb begin
    case (size_n)
      SIZE_BYTE: begin
        be_n    = 4'b0001 << off_n;
        wdata_n = {4{i_rd_value[7:0]}};
      end
      SIZE_HALF: begin
        be_n    = 4'b0011 << off_n;
        wdata_n = {2{i_rd_value[15:0]}};
      end
      default: begin
        be_n    = 4'b1111;
        wdata_n = i_rd_value;
      end
    endcase
  end

  mem_load_align #(
    .SIZE_DATA (SIZE_DATA)
  ) u_load_align (
    .rdata_i  (i_mem_rdata),
    .offset_i (off_q),
    .size_i   (size_q),
    .signed_i (signed_q),
    .data_o   (load_data)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q;

  // Abort on the TIMEOUT_CYCLES-th ACCESS cycle without ack; an ack in that
  // same cycle completes the access instead.
  assign abort = (state_q == ST_ACCESS) && !i_mem_ack &&
                 (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_IDLE) begin
      cnt_d = '0;
    end else if (!i_mem_ack) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= abort;
    end
  end

  assign o_timeout = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign abort     = 1'b0;
  assign o_timeout = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    be_d         = be_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    rd_d         = rd_q;
    size_d       = size_q;
    signed_d     = signed_q;
    off_d        = off_q;
    valid_d      = 1'b0;
    rd_out_d     = rd_out_q;
    result_d     = result_q;
    misaligned_d = 1'b0;
    stall        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          if (!mem_op) begin
            valid_d  = 1'b1;
            result_d = i_alu_result;
            rd_out_d = i_rd;
          end else if (!aligned) begin
            misaligned_d = 1'b1;
          end else begin
            // Stall now so the latch holds while the access is outstanding.
            stall    = 1'b1;
            addr_d   = {i_alu_result[SIZE_DATA-1:2], 2'b00};
            be_d     = be_n;
            we_d     = is_write;
            wdata_d  = wdata_n;
            rd_d     = i_rd;
            size_d   = size_n;
            signed_d = i_signed;
            off_d    = off_n;
            state_d  = ST_ACCESS;
          end
        end
      end

      ST_ACCESS: begin
        if (i_mem_ack) begin
          // Release stall in the ack cycle so the upstream latch advances.
          valid_d  = 1'b1;
          rd_out_d = rd_q;
          result_d = we_q ? '0 : load_data;
          state_d  = ST_IDLE;
        end else if (abort) begin
          state_d = ST_IDLE;
        end else begin
          stall = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      be_q         <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      rd_q         <= '0;
      size_q       <= SIZE_BYTE;
      signed_q     <= 1'b0;
      off_q        <= '0;
      valid_q      <= 1'b0;
      rd_out_q     <= '0;
      result_q     <= '0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      be_q         <= be_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      rd_q         <= rd_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      off_q        <= off_d;
      valid_q      <= valid_d;
      rd_out_q     <= rd_out_d;
      result_q     <= result_d;
      misaligned_q <= misaligned_d;
    end
  end

  // Request is a pure decode of state so reset removes it immediately.
  assign o_mem_req    = (state_q == ST_ACCESS);
  assign o_mem_we     = o_mem_req & we_q;
  assign o_mem_addr   = addr_q;
  assign o_mem_be     = be_q;
  assign o_mem_wdata  = wdata_q;
  assign o_stall      = stall;
  assign o_valid      = valid_q;
  assign o_rd         = rd_out_q;
  assign o_result     = result_q;
  assign o_misaligned = misaligned_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed self-checking bench for mem_access_unit.
// Inputs are driven at the falling edge; outputs are sampled 1ns later,
// well away from the rising (active) edge. Expected writeback values are
// hand-computed and queued in exp_q before each transaction.
// Build with +define+MEM_TIMEOUT_EN to add the watchdog scenario
// (TIMEOUT_CYCLES is set to 4 here).
module tb_mem_access_unit;

  localparam int SIZE_DATA      = 32;
  localparam int SIZE_REG       = 5;
  localparam int TIMEOUT_CYCLES = 4;

  // ---------------- clock / reset ----------------
  logic                 clk;
  logic                 rst_n;
  logic                 i_valid, i_mem_read, i_mem_write, i_signed;
  logic [1:0]           i_size;
  logic [SIZE_REG-1:0]  i_rd;
  logic [SIZE_DATA-1:0] i_alu_result, i_rd_value;
  logic                 o_stall, o_mem_req, o_mem_we;
  logic [SIZE_DATA-1:0] o_mem_addr, o_mem_wdata;
  logic [3:0]           o_mem_be;
  logic                 i_mem_ack;
  logic [SIZE_DATA-1:0] i_mem_rdata;
  logic                 o_valid;
  logic [SIZE_REG-1:0]  o_rd;
  logic [SIZE_DATA-1:0] o_result;
  logic                 o_misaligned, o_timeout;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  mem_access_unit #(
    .SIZE_DATA      (SIZE_DATA),
    .SIZE_REG       (SIZE_REG),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_valid      (i_valid),
    .i_mem_read   (i_mem_read),
    .i_mem_write  (i_mem_write),
    .i_size       (i_size),
    .i_signed     (i_signed),
    .i_rd         (i_rd),
    .i_alu_result (i_alu_result),
    .i_rd_value   (i_rd_value),
    .o_stall      (o_stall),
    .o_mem_req    (o_mem_req),
    .o_mem_we     (o_mem_we),
    .o_mem_addr   (o_mem_addr),
    .o_mem_be     (o_mem_be),
    .o_mem_wdata  (o_mem_wdata),
    .i_mem_ack    (i_mem_ack),
    .i_mem_rdata  (i_mem_rdata),
    .o_valid      (o_valid),
    .o_rd         (o_rd),
    .o_result     (o_result),
    .o_misaligned (o_misaligned),
    .o_timeout    (o_timeout)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [SIZE_DATA-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    i_valid      = 1'b0;
    i_mem_read   = 1'b0;
    i_mem_write  = 1'b0;
    i_size       = 2'b00;
    i_signed     = 1'b0;
    i_rd         = '0;
    i_alu_result = '0;
    i_rd_value   = '0;
  endtask

  // One memory transaction: request cycle, ACCESS with 'waits' wait cycles,
  // ack, then the writeback cycle. Returns at falling edge + 1ns of the
  // cycle in which o_valid is expected, so callers may chain a new op.
  task automatic run_mem(input string tag, input logic rd_en, input logic wr_en,
                         input logic [1:0] sz, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic [4:0] rd, input int waits,
                         input logic [31:0] rdata,
                         input logic [31:0] exp_addr, input logic [3:0] exp_be,
                         input logic exp_we, input logic [31:0] exp_wdata);
    int stall_n;
    int unstable;
    logic [31:0] a0, wd0;
    logic [3:0]  be0;
    logic [31:0] exp_res;
    stall_n  = 0;
    unstable = 0;
    @(negedge clk);
    i_valid      = 1'b1;
    i_mem_read   = rd_en;
    i_mem_write  = wr_en;
    i_size       = sz;
    i_signed     = sgn;
    i_rd         = rd;
    i_alu_result = addr;
    i_rd_value   = data;
    #1;
    if (o_stall) stall_n++;
    @(negedge clk);
    idle_inputs();
    #1;
    a0  = o_mem_addr;
    be0 = o_mem_be;
    wd0 = o_mem_wdata;
    check({tag, " req"},   {31'd0, o_mem_req}, 32'd1);
    check({tag, " addr"},  o_mem_addr, exp_addr);
    check({tag, " be"},    {28'd0, o_mem_be}, {28'd0, exp_be});
    check({tag, " we"},    {31'd0, o_mem_we}, {31'd0, exp_we});
    check({tag, " wdata"}, o_mem_wdata, exp_wdata);
    for (int c = 0; c <= waits; c++) begin
      if (c == waits) begin
        i_mem_ack   = 1'b1;
        i_mem_rdata = rdata;
      end
      #1;
      if (o_stall) stall_n++;
      if (!o_mem_req || o_mem_addr !== a0 || o_mem_be !== be0 || o_mem_wdata !== wd0)
        unstable++;
      @(negedge clk);
      i_mem_ack   = 1'b0;
      i_mem_rdata = '0;
      #1;
    end
    check({tag, " stable"},       unstable, 0);
    check({tag, " stall_cycles"}, stall_n, waits + 1);
    check({tag, " req_drop"},     {31'd0, o_mem_req}, 32'd0);
    check({tag, " valid"},        {31'd0, o_valid}, 32'd1);
    check({tag, " rd"},           {27'd0, o_rd}, {27'd0, rd});
    if (exp_q.size() == 0) begin
      check({tag, " exp_q_empty"}, 32'd1, 32'd0);
    end else begin
      exp_res = exp_q.pop_front();
      check({tag, " result"}, o_result, exp_res);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int seen;
    logic [1:0]  mis_size[2];
    logic [31:0] mis_addr[2];

    idle_inputs();
    i_mem_ack   = 1'b0;
    i_mem_rdata = '0;
    rst_n       = 1'b0;
    #12;
    check("reset valid",      {31'd0, o_valid}, 32'd0);
    check("reset req",        {31'd0, o_mem_req}, 32'd0);
    check("reset stall",      {31'd0, o_stall}, 32'd0);
    check("reset misaligned", {31'd0, o_misaligned}, 32'd0);
    check("reset timeout",    {31'd0, o_timeout}, 32'd0);
    check("reset result",     o_result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ALU pass-through
    @(negedge clk);
    i_valid      = 1'b1;
    i_alu_result = 32'h1234_5678;
    i_rd         = 5'd7;
    #1;
    check("alu stall", {31'd0, o_stall}, 32'd0);
    @(negedge clk);
    idle_inputs();
    #1;
    check("alu valid",  {31'd0, o_valid}, 32'd1);
    check("alu result", o_result, 32'h1234_5678);
    check("alu rd",     {27'd0, o_rd}, 32'd7);
    check("alu stall2", {31'd0, o_stall}, 32'd0);
    @(negedge clk);
    #1;
    check("alu valid_drop", {31'd0, o_valid}, 32'd0);

    // Signed byte load, two wait cycles
    exp_q.push_back(32'hFFFF_FF80);
    run_mem("lb_s", 1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0, 5'd3, 2,
            32'h80AB_CDEF, 32'h0000_0100, 4'b1000, 1'b0, 32'h0);

    // Half store, zero-wait
    exp_q.push_back(32'h0);
    run_mem("sh", 1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0022, 32'h0000_BEEF, 5'd9, 0,
            32'h1111_1111, 32'h0000_0020, 4'b1100, 1'b1, 32'hBEEF_BEEF);

    // Unsigned half load, upper lane
    exp_q.push_back(32'h0000_8765);
    run_mem("lhu", 1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0002, 32'h0, 5'd4, 1,
            32'h8765_4321, 32'h0000_0000, 4'b1100, 1'b0, 32'h0);

    // Signed half load, lower lane
    exp_q.push_back(32'hFFFF_F00D);
    run_mem("lh_s", 1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0004, 32'h0, 5'd5, 0,
            32'h1234_F00D, 32'h0000_0004, 4'b0011, 1'b0, 32'h0);

    // Word load with size code 11
    exp_q.push_back(32'hDEAD_BEEF);
    run_mem("lw_11", 1'b1, 1'b0, 2'b11, 1'b1, 32'h0000_0040, 32'h0, 5'd6, 3,
            32'hDEAD_BEEF, 32'h0000_0040, 4'b1111, 1'b0, 32'h0);

    // Byte store, lane 1
    exp_q.push_back(32'h0);
    run_mem("sb", 1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0011, 32'h1234_56A5, 5'd8, 0,
            32'h0, 32'h0000_0010, 4'b0010, 1'b1, 32'hA5A5_A5A5);

    // Read and write both set: behaves as a read
    exp_q.push_back(32'hCAFE_F00D);
    run_mem("rw_both", 1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_0008, 32'hFFFF_FFFF, 5'd10, 1,
            32'hCAFE_F00D, 32'h0000_0008, 4'b1111, 1'b0, 32'hFFFF_FFFF);

    // Unsigned byte load lane 2, then an ALU op with no bubble
    exp_q.push_back(32'h0000_00AB);
    run_mem("lbu", 1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0102, 32'h0, 5'd11, 0,
            32'h80AB_CDEF, 32'h0000_0100, 4'b0100, 1'b0, 32'h0);
    i_valid      = 1'b1;
    i_alu_result = 32'h0BAD_F00D;
    i_rd         = 5'd12;
    #1;
    check("b2b stall", {31'd0, o_stall}, 32'd0);
    @(negedge clk);
    idle_inputs();
    #1;
    check("b2b valid",  {31'd0, o_valid}, 32'd1);
    check("b2b result", o_result, 32'h0BAD_F00D);
    check("b2b rd",     {27'd0, o_rd}, 32'd12);

    // Misaligned word and half loads
    mis_size[0] = 2'b10; mis_addr[0] = 32'h0000_0001;
    mis_size[1] = 2'b01; mis_addr[1] = 32'h0000_0003;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      i_valid      = 1'b1;
      i_mem_read   = 1'b1;
      i_size       = mis_size[k];
      i_alu_result = mis_addr[k];
      #1;
      check("mis stall", {31'd0, o_stall}, 32'd0);
      @(negedge clk);
      idle_inputs();
      #1;
      check("mis pulse", {31'd0, o_misaligned}, 32'd1);
      check("mis valid", {31'd0, o_valid}, 32'd0);
      check("mis req",   {31'd0, o_mem_req}, 32'd0);
      @(negedge clk);
      #1;
      check("mis pulse_end", {31'd0, o_misaligned}, 32'd0);
      check("mis req2",      {31'd0, o_mem_req}, 32'd0);
    end

    // Ack while idle is ignored
    @(negedge clk);
    i_mem_ack   = 1'b1;
    i_mem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    i_mem_ack = 1'b0;
    #1;
    check("idle_ack valid", {31'd0, o_valid}, 32'd0);

    // Reset in the middle of an access
    @(negedge clk);
    i_valid      = 1'b1;
    i_mem_read   = 1'b1;
    i_size       = 2'b10;
    i_alu_result = 32'h0000_0080;
    i_rd         = 5'd13;
    @(negedge clk);
    idle_inputs();
    #1;
    check("rst_mid req_before", {31'd0, o_mem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid req",   {31'd0, o_mem_req}, 32'd0);
    check("rst_mid stall", {31'd0, o_stall}, 32'd0);
    check("rst_mid valid", {31'd0, o_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    i_mem_ack   = 1'b1;
    i_mem_rdata = 32'h0000_0001;
    @(negedge clk);
    i_mem_ack = 1'b0;
    #1;
    check("rst_mid late_ack valid", {31'd0, o_valid}, 32'd0);

`ifdef MEM_TIMEOUT_EN
    // Watchdog: no ack ever arrives
    begin
      int   req_n;
      logic last_stall;
      req_n      = 0;
      last_stall = 1'b1;
      @(negedge clk);
      i_valid      = 1'b1;
      i_mem_read   = 1'b1;
      i_size       = 2'b10;
      i_alu_result = 32'h0000_0200;
      i_rd         = 5'd14;
      @(negedge clk);
      idle_inputs();
      #1;
      for (int c = 0; c < 20; c++) begin
        if (!o_mem_req) break;
        req_n++;
        last_stall = o_stall;
        @(negedge clk);
        #1;
      end
      check("tmo req_cycles",  req_n, TIMEOUT_CYCLES);
      check("tmo abort_stall", {31'd0, last_stall}, 32'd0);
      check("tmo pulse",       {31'd0, o_timeout}, 32'd1);
      check("tmo valid",       {31'd0, o_valid}, 32'd0);
      @(negedge clk);
      #1;
      check("tmo pulse_end", {31'd0, o_timeout}, 32'd0);
    end
`endif

    check("timeout idle", {31'd0, o_timeout}, 32'd0);
    check("exp_q drained", exp_q.size(), 0);

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end expected end");
    $fatal(1, "bench watchdog expired");
  end

endmodule
